// File: rtl/id_inst_queue_pkg.sv
// id_inst_queue_pkg: shared entry width helper and delay-slot state encodings
// Optional feature macro: DELAY_SLOT_KEEP_EN
package id_inst_queue_pkg;
  typedef enum logic {IDLE = 1'b0, DS_WAIT = 1'b1} ds_state_t;
  function automatic int instq_entry_wd(input int pc_w, input int inst_w);
    return pc_w + inst_w;
  endfunction
endpackage

// File: rtl/id_inst_queue_ctrl.sv
// id_inst_queue_ctrl: pointers, occupancy and flush/delay-slot control for the IF->ID queue
// Ports: clk, rst, in_valid, out_ready, flush in; rd_ptr, wr_ptr, count, we (storage write enable) out
// Optional feature macro: DELAY_SLOT_KEEP_EN (keep the delay slot across a flush)
module id_inst_queue_ctrl
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     we
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic          push;
  logic          pop;
  logic [PW-1:0] rd_nxt;
  assign push   = in_valid & (count != CW'(DEPTH));
  assign pop    = out_ready & (count != '0);
  assign rd_nxt = rd_ptr + PW'(pop);
`ifdef DELAY_SLOT_KEEP_EN
  ds_state_t state;
  logic      keep;
  logic      ds_push;
  logic      hold;
  // keep: an entry survives the flush-cycle pop, so it is the delay slot
  assign keep    = (count - CW'(pop)) != '0;
  // ds_push: with nothing left, a same-cycle push is the delay slot
  assign ds_push = push & (state == IDLE);
  assign hold    = keep | ds_push;
  assign we      = flush ? (ds_push & ~keep) : push;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else if (flush) begin
      rd_ptr <= rd_nxt;
      wr_ptr <= rd_nxt + PW'(hold);
      count  <= CW'(hold);
      state  <= hold ? IDLE : DS_WAIT;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PW'(we);
      count  <= count + CW'(we) - CW'(pop);
      state  <= push ? IDLE : state;
    end
  end
`else
  assign we = push & ~flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PW'(we);
      count  <= count + CW'(we) - CW'(pop);
    end
  end
`endif
endmodule

// File: rtl/id_inst_queue.sv
// id_inst_queue: DEPTH-entry {pc, inst} FIFO between IF and ID with branch flush
// Ports: in_valid/in_pc/in_inst/in_ready push side; out_valid/out_pc/out_inst/out_ready pop side;
//        flush from ID branch; count occupancy; afull stall hint to IF
// Optional feature macro: DELAY_SLOT_KEEP_EN (keep the delay slot across a flush)
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_W      = 32,
  parameter int INST_W    = 32,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [INST_W-1:0]      in_inst,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [PC_W-1:0]        out_pc,
  output logic [INST_W-1:0]      out_inst,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   afull
);
  localparam int EW = instq_entry_wd(PC_W, INST_W);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [EW-1:0]            mem [DEPTH];
  logic [$clog2(DEPTH)-1:0] rd_ptr;
  logic [$clog2(DEPTH)-1:0] wr_ptr;
  logic                     we;
  logic [EW-1:0]            head;
  id_inst_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .flush    (flush),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (count),
    .we       (we)
  );
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= {in_pc, in_inst};
  end
  assign head      = mem[rd_ptr];
  assign out_valid = count != '0;
  assign out_pc    = out_valid ? head[EW-1:INST_W] : '0;
  assign out_inst  = out_valid ? head[INST_W-1:0] : '0;
  assign in_ready  = count != CW'(DEPTH);
  assign afull     = count >= CW'(AFULL_LVL);
endmodule

// File: tb/tb_id_inst_queue.sv
// tb_id_inst_queue: directed table plus multi-cycle sequences for id_inst_queue (DEPTH=4)
module tb_id_inst_queue;
  localparam logic [31:0] A = 32'hBFC0_0000;
  localparam logic [31:0] T = 32'h8000_1000;
  localparam logic [31:0] K = 32'h1234_5678;
  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;
  logic        afull;
  int          total = 0;
  int          bad = 0;
  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        fl;
    int          cnt;
    logic        v;
    logic [31:0] hpc;
    logic        ir;
    logic        af;
  } vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32), .AFULL_LVL(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_inst  (in_inst),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_inst (out_inst),
    .out_ready(out_ready),
    .flush    (flush),
    .count    (count),
    .afull    (afull)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic state(input string name, input int cnt, input logic [31:0] hpc);
    logic v;
    v = cnt != 0;
    chk({name, ".count"}, 64'(count), 64'(cnt));
    chk({name, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({name, ".out_pc"}, 64'(out_pc), v ? 64'(hpc) : 64'd0);
    chk({name, ".out_inst"}, 64'(out_inst), v ? 64'(hpc ^ K) : 64'd0);
    chk({name, ".in_ready"}, 64'(in_ready), 64'(cnt != 4));
    chk({name, ".afull"}, 64'(afull), 64'(cnt >= 3));
  endtask
  task automatic step(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = pc ^ K;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1;
    step(1, A, 1, 1);
    step(1, A, 1, 1);
    state("reset", 0, 0);
    rst = 0;
    tbl[0]  = '{1, A,        0, 0, 1, 1, A,        1, 0};
    tbl[1]  = '{1, A + 4,    0, 0, 2, 1, A,        1, 0};
    tbl[2]  = '{1, A + 8,    0, 0, 3, 1, A,        1, 1};
    tbl[3]  = '{1, A + 12,   0, 0, 4, 1, A,        0, 1};
    tbl[4]  = '{1, A + 16,   0, 0, 4, 1, A,        0, 1};
    tbl[5]  = '{1, A + 16,   1, 0, 3, 1, A + 4,    1, 1};
    tbl[6]  = '{1, A + 16,   0, 0, 4, 1, A + 4,    0, 1};
    tbl[7]  = '{0, 0,        1, 0, 3, 1, A + 8,    1, 1};
    tbl[8]  = '{0, 0,        1, 0, 2, 1, A + 12,   1, 0};
    tbl[9]  = '{0, 0,        1, 0, 1, 1, A + 16,   1, 0};
    tbl[10] = '{0, 0,        1, 0, 0, 0, 0,        1, 0};
    tbl[11] = '{0, 0,        1, 0, 0, 0, 0,        1, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].iv, tbl[i].pc, tbl[i].ordy, tbl[i].fl);
      state($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].hpc);
    end
    step(1, 32'h1000, 0, 0);
    state("wrap0", 1, 32'h1000);
    for (int i = 1; i <= 10; i++) begin
      step(1, 32'h1000 + 32'(4 * i), 1, 0);
      state($sformatf("wrap%0d", i), 1, 32'h1000 + 32'(4 * i));
    end
    step(0, 0, 1, 0);
    state("wrap_drain", 0, 0);
    step(1, A, 0, 0);
    step(1, A + 4, 0, 0);
    step(1, A + 8, 0, 0);
    state("fl_fill", 3, A);
    step(0, 0, 1, 1);
`ifdef DELAY_SLOT_KEEP_EN
    state("fl_keep", 1, A + 4);
    step(1, T, 0, 0);
    state("fl_tgt", 2, A + 4);
    step(0, 0, 1, 0);
    state("fl_tgt_head", 1, T);
    step(0, 0, 1, 0);
    state("fl_drain", 0, 0);
    step(1, A, 0, 0);
    step(0, 0, 1, 1);
    state("ds_wait", 0, 0);
    step(1, A + 4, 0, 0);
    state("ds_slot", 1, A + 4);
    step(1, T, 0, 0);
    state("ds_tgt", 2, A + 4);
    step(0, 0, 1, 0);
    state("ds_order", 1, T);
    step(0, 0, 1, 0);
    state("ds_drain", 0, 0);
`else
    state("fl_base", 0, 0);
    step(1, T, 0, 0);
    state("fl_tgt", 1, T);
    step(1, A, 1, 1);
    state("fl_push_drop", 0, 0);
    step(1, T + 4, 0, 0);
    state("fl_after", 1, T + 4);
`endif
    step(1, A, 0, 0);
    rst = 1;
    step(1, A, 0, 1);
    state("rst_prio", 0, 0);
    rst = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_inst_queue.md
Name: id_inst_queue

Overview:
- Parametrised instruction queue between IF and ID; generalises the single-entry stall capture of the current decode stage into a DEPTH-entry FIFO of {pc, inst} pairs.
- Decouples SRAM fetch from decode stalls; IF pushes fetched words, ID pops one per cycle when not stalled.
- Branch redirect (br_e from ID) flushes younger wrong-path entries.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- PC_W, 32, pc width
- INST_W, 32, instruction width
- AFULL_LVL, DEPTH-1, occupancy at or above which afull asserts

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  IF presents a fetched instruction
- in_pc  in  PC_W  pc of pushed instruction
- in_inst  in  INST_W  instruction word (inst_sram_rdata)
- in_ready  out  1  queue can accept; equals !full
- out_valid  out  1  head entry valid
- out_pc  out  PC_W  head pc
- out_inst  out  INST_W  head instruction; zero when !out_valid
- out_ready  in  1  ID consumes head this cycle (ID not stalled)
- flush  in  1  branch taken in ID; discard wrong-path entries
- count  out  $clog2(DEPTH)+1  current occupancy
- afull  out  1  count >= AFULL_LVL; IF uses it as stall request

Behaviour:
- Reset: rd/wr pointers 0, count 0, out_valid 0, out_pc 0, out_inst 0, in_ready 1, afull 0; DS state IDLE.
- Storage: DEPTH-entry register array; pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from count.
- Push: the entry is written when in_valid & in_ready. It becomes visible at the head one cycle later (latency 1); there is no combinational in-to-out bypass.
- Pop: the head advances when out_valid & out_ready. out_* are combinational from the head entry.
- Simultaneous push and pop: count is unchanged. When full, in_ready is 0 even if out_ready is 1, so there is no push-on-pop when full.
- Pop while empty: ignored. Push while full: ignored (in_ready = 0), and the data is not stored.
- Flush (baseline): next cycle count = 0 and rd_ptr = wr_ptr. A push in the flush cycle is dropped. A pop in the flush cycle completes normally, because the head is the branch itself.
- Flush has priority over push. rst has priority over flush.
- afull and in_ready are combinational from registered count.

Optional Feature:
- Macro: DELAY_SLOT_KEEP_EN.
- Defined: MIPS delay-slot preservation on flush.
  - If, after the flush-cycle pop, an entry remains at the head, that one entry is retained (count becomes 1) and all others are discarded.
  - If none remains, the state goes IDLE -> DS_WAIT. In DS_WAIT, non-delay-slot pushes are not stored; the first accepted push is stored as the delay slot and the state returns to IDLE.
  - A push in the same cycle as the flush with the queue otherwise empty is that delay slot and is kept.
  - A flush while in DS_WAIT restarts DS_WAIT.
  - rst forces IDLE.
- Undefined: flush empties the queue as in baseline; no DS state.

Decomposition:
- Shared package/header (lib/defines.vh style): INSTQ_ENTRY_WD = PC_W+INST_W, and DS state encodings IDLE = 1'b0, DS_WAIT = 1'b1.
- One natural sub-module: id_inst_queue_ctrl (pointers, count, flush/DS state machine). Storage array and head mux stay in the top.

Test Plan:
- Reset then idle: out_valid=0, count=0, in_ready=1, afull=0, out_inst=0.
- Push pc 0xBFC00000..0xBFC0000C with out_ready=0 (DEPTH=4): count 1..4, afull at count 3, in_ready=0 at 4. A fifth push of 0xBFC00010 is not stored. Pop then yields 0xBFC00000 first.
- Full queue with simultaneous in_valid=1, out_ready=1: head pops, the push is refused, and count drops to 3. The next cycle the push is accepted and count is back to 4.
- Wrap: 10 push/pop pairs at steady state with DEPTH=4. The pc sequence out matches the sequence in, count stays at 1, and both pointers wrap twice.
- Flush baseline: queue holds pcs A, A+4, A+8; pop A with flush=1 → next cycle count=0. A push of target T in the following cycle appears at the head.
- Flush with DELAY_SLOT_KEEP_EN on the same case → count=1, head=A+4, and A+8 is discarded. In the empty-queue variant, the first push (pc A+4) is kept, the next push T is stored, and out order is A+4, T.
